// File: rtl/fir_axis_mc.sv
`default_nettype none
// ============================================================================
// fir_axis_mc : time-multiplexed multichannel FIR, AXI-Stream style I/O, FWFT output FIFO.
// Optional macro FIR_AXIS_SAT_EN: saturating output with sticky SAT_FLAG (default wraps).
// Revision 1.0
// ============================================================================
module fir_axis_mc #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                             S_AXIS_ACLK,
  input  logic                                             S_AXIS_ARESET,
  output logic                                             S_AXIS_TREADY,
  input  logic [DATA_W-1:0]                                S_AXIS_TDATA,
  input  logic                                             S_AXIS_TLAST,
  input  logic                                             S_AXIS_TVALID,
  input  logic                                             S_AXIS_RREADY,
  output logic [OUT_W-1:0]                                 S_AXIS_RDATA,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] S_AXIS_RCHAN,
  output logic                                             S_AXIS_RLAST,
  output logic                                             S_AXIS_RVALID,
  input  logic                                             COEF_WE,
  input  logic [$clog2(TAPS)-1:0]                          COEF_ADDR,
  input  logic [COEF_W-1:0]                                COEF_DATA,
  output logic                                             COEF_ERR,
  output logic                                             SAT_FLAG
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TAP_W  = $clog2(TAPS);
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + TAP_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_PUSH = 2'd2;

  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(64'd1 << SHIFT);

  logic clk;
  logic rst;
  assign clk = S_AXIS_ACLK;
  assign rst = S_AXIS_ARESET;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic                     tready_int;
  logic                     mac_en;
  logic                     push;
  logic                     accept;
  logic                     pop;
  logic [CH_W-1:0]          in_ch;
  logic [CH_W-1:0]          cur_ch;
  logic                     cur_last;
  logic [TAP_W-1:0]         tap;
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
  logic signed [DATA_W-1:0] sample_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         result;

  logic [OUT_W-1:0]         f_data [FIFO_DEPTH];
  logic [CH_W-1:0]          f_chan [FIFO_DEPTH];
  logic                     f_last [FIFO_DEPTH];
  logic [FA_W-1:0]          wr_ptr;
  logic [FA_W-1:0]          rd_ptr;
  logic [FA_W:0]            count;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_MAC;
      S_MAC:   if (tap == TAP_W'(TAPS - 1)) state_nxt = S_PUSH;
      S_PUSH:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ready is gated by reset so the input never looks ready while reset is held.
  always_comb begin
    tready_int = 1'b0;
    mac_en     = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE:  tready_int = !rst && (count < (FA_W + 1)'(FIFO_DEPTH));
      S_MAC:   mac_en = 1'b1;
      S_PUSH:  push = 1'b1;
      default: ;
    endcase
  end

  assign accept        = tready_int && S_AXIS_TVALID;
  assign S_AXIS_TREADY = tready_int;

  // ---------------- input side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ch    <= '0;
      cur_ch   <= '0;
      cur_last <= 1'b0;
    end else if (accept) begin
      cur_ch   <= in_ch;
      cur_last <= S_AXIS_TLAST;
      if (S_AXIS_TLAST || in_ch == CH_W'(CHANNELS - 1)) in_ch <= '0;
      else                                               in_ch <= in_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          dline[c][t] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept && in_ch == CH_W'(c)) begin
          dline[c][0] <= S_AXIS_TDATA;
          for (int t = 1; t < TAPS; t++) dline[c][t] <= dline[c][t-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) coef[t] <= (t == 0) ? COEF_ONE : '0;
      COEF_ERR <= 1'b0;
    end else begin
      COEF_ERR <= COEF_WE && (state != S_IDLE);
      if (COEF_WE && state == S_IDLE) begin
        for (int t = 0; t < TAPS; t++)
          if (COEF_ADDR == TAP_W'(t)) coef[t] <= COEF_DATA;
      end
    end
  end

  // ---------------- multiply-accumulate ----------------
  always_comb begin
    sample_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (cur_ch == CH_W'(c)) sample_sel = dline[c][tap];
  end

  assign prod = sample_sel * coef[tap];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      tap <= '0;
    end else if (accept) begin
      acc <= '0;
      tap <= '0;
    end else if (mac_en) begin
      acc <= acc + {{TAP_W{prod[PROD_W-1]}}, prod};
      tap <= tap + TAP_W'(1);
    end
  end

  assign shifted = acc >>> SHIFT;

`ifdef FIR_AXIS_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic sat_hit;
  logic sat_r;

  always_comb begin
    result  = shifted[OUT_W-1:0];
    sat_hit = 1'b0;
    if (shifted > OUT_MAX) begin
      result  = OUT_MAX[OUT_W-1:0];
      sat_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      result  = OUT_MIN[OUT_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  sat_r <= 1'b0;
    else if (push && sat_hit) sat_r <= 1'b1;
  end
  assign SAT_FLAG = sat_r;
`else
  logic unused_hi;
  assign result    = shifted[OUT_W-1:0];
  assign unused_hi = ^shifted[ACC_W-1:OUT_W];
  assign SAT_FLAG  = 1'b0;
`endif

  // ---------------- output FIFO (first-word fall-through) ----------------
  assign pop = (count != '0) && S_AXIS_RREADY;

  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wr_ptr] <= result;
      f_chan[wr_ptr] <= cur_ch;
      f_last[wr_ptr] <= cur_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FA_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FA_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (FA_W + 1)'(1);
        2'b01:   count <= count - (FA_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // Outputs read as zero whenever the FIFO is empty.
  assign S_AXIS_RVALID = (count != '0);
  assign S_AXIS_RDATA  = S_AXIS_RVALID ? f_data[rd_ptr] : '0;
  assign S_AXIS_RCHAN  = S_AXIS_RVALID ? f_chan[rd_ptr] : '0;
  assign S_AXIS_RLAST  = S_AXIS_RVALID ? f_last[rd_ptr] : 1'b0;

endmodule
`default_nettype wire
